// File: rtl/checkpoint_nmr_bcast.sv
// checkpoint_nmr_bcast: enumerates 1..MAX_CORES logical cores on a checkpoint request, queues one
// {physical_id, task_id} record per core and drains them as Avalon-MM writes. Macro CHECKPOINT_TIMEOUT_EN adds a waitrequest timeout.
module checkpoint_nmr_bcast #(
  parameter int                KEY_W          = 4,
  parameter int                MAX_CORES      = 4,
  parameter int                LID_W          = 2,
  parameter int                CNT_W          = 3,
  parameter int                FIFO_DEPTH     = 8,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = {ADDR_W{1'b0}},
  parameter int                ADDR_SHIFT     = 20,
  parameter int                TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         comparator_checkpoint,
  input  logic [KEY_W-1:0]             comparator_task_id,
  input  logic [CNT_W-1:0]             checkpoint_count,
  output logic                         checkpoint_ack,
  output logic [LID_W-1:0]             checkpoint_logical_core_id,
  input  logic [KEY_W-1:0]             checkpoint_physical_core_id,
  output logic                         checkpoint_write,
  output logic [ADDR_W-1:0]            checkpoint_address,
  output logic [DATA_W-1:0]            checkpoint_writedata,
  input  logic                         checkpoint_waitrequest,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         timeout_err
);

  localparam int FAW   = $clog2(FIFO_DEPTH);
  localparam int LVL_W = FAW + 1;
  localparam int REC_W = 2 * KEY_W;

  if ((2 ** LID_W) < MAX_CORES || MAX_CORES < 1 || MAX_CORES >= (2 ** CNT_W) ||
      DATA_W < (2 * KEY_W + 1) || FIFO_DEPTH < 2 || (2 ** FAW) != FIFO_DEPTH ||
      TIMEOUT_CYCLES < 2) begin : g_param_err
    $error("checkpoint_nmr_bcast: illegal parameter combination");
  end

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ENUM = 2'd1, R_ACK = 2'd2} req_state_e;
  typedef enum logic [1:0] {D_IDLE = 2'd0, D_RD = 2'd1, D_WR = 2'd2} drn_state_e;

  req_state_e             req_state_r, req_next_s;
  drn_state_e             d_state_r, d_next_s;
  logic [KEY_W-1:0]       task_r;
  logic [CNT_W-1:0]       cnt_r, cnt_eff_s;
  logic [LID_W-1:0]       lid_r;
  logic                   ack_r;
  logic                   push_s, pop_s, done_s, last_s, full_s, empty_s, timeout_s;
  logic [REC_W-1:0]       mem_r [FIFO_DEPTH];
  logic [FAW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]       level_r;
  logic [REC_W-1:0]       rd_data_r;
  logic                   write_r;
  logic [ADDR_W-1:0]      addr_r;
  logic [DATA_W-1:0]      data_r;

  assign full_s  = (level_r == LVL_W'(FIFO_DEPTH));
  assign empty_s = (level_r == {LVL_W{1'b0}});
  assign last_s  = ((32'(lid_r) + 32'd1) == 32'(cnt_r));

  // Clamp the requested redundancy degree into 1..MAX_CORES.
  always_comb begin
    cnt_eff_s = checkpoint_count;
    if (checkpoint_count == {CNT_W{1'b0}}) begin
      cnt_eff_s = CNT_W'(1);
    end else if (checkpoint_count > CNT_W'(MAX_CORES)) begin
      cnt_eff_s = CNT_W'(MAX_CORES);
    end else begin
      cnt_eff_s = checkpoint_count;
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_state_r <= R_IDLE;
    end else begin
      req_state_r <= req_next_s;
    end
  end

  // Request FSM next state; a push blocked by a full FIFO keeps the FSM in ENUM.
  always_comb begin
    req_next_s = req_state_r;
    case (req_state_r)
      R_IDLE:  if (comparator_checkpoint) req_next_s = R_ENUM; else req_next_s = R_IDLE;
      R_ENUM:  if (!full_s && last_s) req_next_s = R_ACK; else req_next_s = R_ENUM;
      R_ACK:   req_next_s = R_IDLE;
      default: req_next_s = R_IDLE;
    endcase
  end

  // Request FSM outputs.
  always_comb begin
    push_s = 1'b0;
    case (req_state_r)
      R_ENUM:  push_s = !full_s;
      default: push_s = 1'b0;
    endcase
  end

  // Latched request context, logical core enumeration and ack pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      task_r <= {KEY_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      lid_r  <= {LID_W{1'b0}};
      ack_r  <= 1'b0;
    end else begin
      ack_r <= (req_next_s == R_ACK);
      if (req_state_r == R_IDLE && comparator_checkpoint) begin
        task_r <= comparator_task_id;
        cnt_r  <= cnt_eff_s;
        lid_r  <= {LID_W{1'b0}};
      end else if (req_state_r == R_ENUM && push_s && !last_s) begin
        lid_r <= lid_r + LID_W'(1);
      end else if (req_state_r == R_ACK) begin
        lid_r <= {LID_W{1'b0}};
      end
    end
  end

  // Record FIFO with registered read port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {REC_W{1'b0}};
      wr_ptr_r  <= {FAW{1'b0}};
      rd_ptr_r  <= {FAW{1'b0}};
      level_r   <= {LVL_W{1'b0}};
      rd_data_r <= {REC_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {checkpoint_physical_core_id, task_r};
        wr_ptr_r        <= wr_ptr_r + FAW'(1);
      end
      if (pop_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
        rd_ptr_r  <= rd_ptr_r + FAW'(1);
      end
      level_r <= level_r + LVL_W'(push_s) - LVL_W'(pop_s);
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_state_r <= D_IDLE;
    end else begin
      d_state_r <= d_next_s;
    end
  end

  // Drain FSM outputs: a write ends on acceptance or on timeout; refill the pipe straight away.
  always_comb begin
    done_s = 1'b0;
    pop_s  = 1'b0;
    case (d_state_r)
      D_IDLE: begin
        done_s = 1'b0;
        pop_s  = !empty_s;
      end
      D_WR: begin
        done_s = !checkpoint_waitrequest || timeout_s;
        pop_s  = done_s && !empty_s;
      end
      default: begin
        done_s = 1'b0;
        pop_s  = 1'b0;
      end
    endcase
  end

  // Drain FSM next state.
  always_comb begin
    d_next_s = d_state_r;
    case (d_state_r)
      D_IDLE:  if (!empty_s) d_next_s = D_RD; else d_next_s = D_IDLE;
      D_RD:    d_next_s = D_WR;
      D_WR: begin
        if (done_s) begin
          if (!empty_s) d_next_s = D_RD; else d_next_s = D_IDLE;
        end else begin
          d_next_s = D_WR;
        end
      end
      default: d_next_s = D_IDLE;
    endcase
  end

  // Avalon master outputs; address/data are loaded in D_RD and held through D_WR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else begin
      write_r <= (d_next_s == D_WR);
      if (d_state_r == D_RD) begin
        addr_r <= BASE_ADDR + (ADDR_W'(rd_data_r[REC_W-1:KEY_W]) << ADDR_SHIFT);
        data_r <= DATA_W'({1'b1, rd_data_r});
      end
    end
  end

`ifdef CHECKPOINT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_err_r;

  assign timeout_s = (d_state_r == D_WR) && checkpoint_waitrequest &&
                     (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // Stall counter for the current write and sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_r      <= {TO_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      if (d_state_r == D_WR && d_next_s == D_WR && checkpoint_waitrequest) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end else begin
        to_cnt_r <= {TO_W{1'b0}};
      end
      timeout_err_r <= timeout_err_r | timeout_s;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_s   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign checkpoint_ack             = ack_r;
  assign checkpoint_logical_core_id = lid_r;
  assign checkpoint_write           = write_r;
  assign checkpoint_address         = addr_r;
  assign checkpoint_writedata       = data_r;
  assign fifo_level                 = level_r;

endmodule

// File: tb/tb_checkpoint_nmr_bcast.sv
// Directed bench for checkpoint_nmr_bcast (FIFO_DEPTH=2, TIMEOUT_CYCLES=16); a bench-side table plays the CSR mapping.
module tb_checkpoint_nmr_bcast;
  localparam int KEY_W = 4, LID_W = 2, CNT_W = 3, FD = 2, ADDR_W = 32, DATA_W = 32;

  logic                  clk;
  logic                  reset_n;
  logic                  comparator_checkpoint;
  logic [KEY_W-1:0]      comparator_task_id;
  logic [CNT_W-1:0]      checkpoint_count;
  logic                  checkpoint_ack;
  logic [LID_W-1:0]      checkpoint_logical_core_id;
  logic [KEY_W-1:0]      checkpoint_physical_core_id;
  logic                  checkpoint_write;
  logic [ADDR_W-1:0]     checkpoint_address;
  logic [DATA_W-1:0]     checkpoint_writedata;
  logic                  checkpoint_waitrequest;
  logic [$clog2(FD):0]   fifo_level;
  logic                  timeout_err;

  logic [KEY_W-1:0]      phys_tab [0:3];
  logic [31:0]           wr_addr_q [$];
  logic [31:0]           wr_data_q [$];
  int                    checks = 0;
  int                    failures = 0;

  checkpoint_nmr_bcast #(.FIFO_DEPTH(FD), .TIMEOUT_CYCLES(16)) dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .comparator_checkpoint       (comparator_checkpoint),
    .comparator_task_id          (comparator_task_id),
    .checkpoint_count            (checkpoint_count),
    .checkpoint_ack              (checkpoint_ack),
    .checkpoint_logical_core_id  (checkpoint_logical_core_id),
    .checkpoint_physical_core_id (checkpoint_physical_core_id),
    .checkpoint_write            (checkpoint_write),
    .checkpoint_address          (checkpoint_address),
    .checkpoint_writedata        (checkpoint_writedata),
    .checkpoint_waitrequest      (checkpoint_waitrequest),
    .fifo_level                  (fifo_level),
    .timeout_err                 (timeout_err)
  );

  assign checkpoint_physical_core_id = phys_tab[checkpoint_logical_core_id];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted writes, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n && checkpoint_write && !checkpoint_waitrequest) begin
      wr_addr_q.push_back(checkpoint_address);
      wr_data_q.push_back(checkpoint_writedata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_ckpt(input logic [KEY_W-1:0] tid, input logic [CNT_W-1:0] cnt);
    comparator_task_id    = tid;
    checkpoint_count      = cnt;
    comparator_checkpoint = 1'b1;
    tick();
    comparator_checkpoint = 1'b0;
  endtask

  // Cycles from the request cycle to the ack cycle, or -1 when no ack shows up.
  task automatic wait_ack(output int n);
    n = 1;
    while (!checkpoint_ack && n < 60) begin
      tick();
      n++;
    end
    if (!checkpoint_ack) n = -1;
  endtask

  task automatic clear_wr();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic expect_wr(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    if (idx < wr_addr_q.size()) begin
      check_eq({tag, "_addr"}, wr_addr_q[idx], ea);
      check_eq({tag, "_data"}, wr_data_q[idx], ed);
    end
  endtask

  initial begin
    int n;
    reset_n                = 1'b0;
    comparator_checkpoint  = 1'b0;
    comparator_task_id     = 4'h0;
    checkpoint_count       = 3'd0;
    checkpoint_waitrequest = 1'b0;
    phys_tab[0] = 4'h0; phys_tab[1] = 4'h0; phys_tab[2] = 4'h0; phys_tab[3] = 4'h0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_write", 32'(checkpoint_write), 32'd0);
    check_eq("rst_ack", 32'(checkpoint_ack), 32'd0);
    check_eq("rst_lid", 32'(checkpoint_logical_core_id), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_addr", checkpoint_address, 32'h0);
    check_eq("rst_data", checkpoint_writedata, 32'h0);
    check_eq("rst_terr", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // TMR, no backpressure
    phys_tab[0] = 4'h3; phys_tab[1] = 4'h7; phys_tab[2] = 4'h9;
    clear_wr();
    start_ckpt(4'h5, 3'd3);
    wait_ack(n);
    check_eq("tmr_ack_lat", 32'(n), 32'd4);
    tick();
    check_eq("tmr_ack_pulse", 32'(checkpoint_ack), 32'd0);
    repeat (10) tick();
    check_eq("tmr_nwr", 32'(wr_addr_q.size()), 32'd3);
    expect_wr("tmr0", 0, 32'h0030_0000, 32'h135);
    expect_wr("tmr1", 1, 32'h0070_0000, 32'h175);
    expect_wr("tmr2", 2, 32'h0090_0000, 32'h195);

    // count=0 clamps to one core
    phys_tab[0] = 4'h2;
    clear_wr();
    start_ckpt(4'hA, 3'd0);
    wait_ack(n);
    check_eq("cnt0_ack_lat", 32'(n), 32'd2);
    repeat (8) tick();
    check_eq("cnt0_nwr", 32'(wr_addr_q.size()), 32'd1);
    expect_wr("cnt0", 0, 32'h0020_0000, 32'h12A);

    // count=7 clamps to MAX_CORES
    phys_tab[0] = 4'h1; phys_tab[1] = 4'h2; phys_tab[2] = 4'h3; phys_tab[3] = 4'h4;
    clear_wr();
    start_ckpt(4'h3, 3'd7);
    wait_ack(n);
    check_eq("cnt7_ack_seen", 32'(n > 0), 32'd1);
    repeat (12) tick();
    check_eq("cnt7_nwr", 32'(wr_addr_q.size()), 32'd4);
    expect_wr("cnt7_0", 0, 32'h0010_0000, 32'h113);
    expect_wr("cnt7_1", 1, 32'h0020_0000, 32'h123);
    expect_wr("cnt7_2", 2, 32'h0030_0000, 32'h133);
    expect_wr("cnt7_3", 3, 32'h0040_0000, 32'h143);

    // Full FIFO stalls ENUM while the drain is stuck on a prior write
    clear_wr();
    checkpoint_waitrequest = 1'b1;
    phys_tab[0] = 4'hE;
    start_ckpt(4'h1, 3'd1);
    wait_ack(n);
    check_eq("pre_ack_lat", 32'(n), 32'd2);
    repeat (4) tick();
    check_eq("pre_write", 32'(checkpoint_write), 32'd1);
    phys_tab[0] = 4'h5; phys_tab[1] = 4'h6; phys_tab[2] = 4'h7; phys_tab[3] = 4'h8;
    start_ckpt(4'h2, 3'd4);
    repeat (6) tick();
    check_eq("stall_lid", 32'(checkpoint_logical_core_id), 32'd2);
    check_eq("stall_level", 32'(fifo_level), 32'd2);
    check_eq("stall_ack", 32'(checkpoint_ack), 32'd0);
    check_eq("stall_addr", checkpoint_address, 32'h00E0_0000);
    check_eq("stall_data", checkpoint_writedata, 32'h1E1);
    check_eq("stall_nwr", 32'(wr_addr_q.size()), 32'd0);
    checkpoint_waitrequest = 1'b0;
    wait_ack(n);
    check_eq("stall_ack_seen", 32'(n > 0), 32'd1);
    repeat (12) tick();
    check_eq("stall_nwr_end", 32'(wr_addr_q.size()), 32'd5);
    expect_wr("stall0", 0, 32'h00E0_0000, 32'h1E1);
    expect_wr("stall1", 1, 32'h0050_0000, 32'h152);
    expect_wr("stall2", 2, 32'h0060_0000, 32'h162);
    expect_wr("stall3", 3, 32'h0070_0000, 32'h172);
    expect_wr("stall4", 4, 32'h0080_0000, 32'h182);

    // waitrequest 1,1,0 keeps the write stable and accepts it once
    clear_wr();
    checkpoint_waitrequest = 1'b1;
    phys_tab[0] = 4'hB;
    start_ckpt(4'h4, 3'd1);
    for (int k = 0; k < 20; k++) begin
      if (checkpoint_write) break;
      tick();
    end
    check_eq("wr1_write", 32'(checkpoint_write), 32'd1);
    check_eq("wr1_addr", checkpoint_address, 32'h00B0_0000);
    check_eq("wr1_data", checkpoint_writedata, 32'h1B4);
    tick();
    check_eq("wr2_write", 32'(checkpoint_write), 32'd1);
    check_eq("wr2_addr", checkpoint_address, 32'h00B0_0000);
    check_eq("wr2_data", checkpoint_writedata, 32'h1B4);
    tick();
    check_eq("wr3_write", 32'(checkpoint_write), 32'd1);
    check_eq("wr3_addr", checkpoint_address, 32'h00B0_0000);
    checkpoint_waitrequest = 1'b0;
    tick();
    check_eq("wr4_write", 32'(checkpoint_write), 32'd0);
    repeat (4) tick();
    check_eq("wr_once", 32'(wr_addr_q.size()), 32'd1);

    // Reset in the middle of a write
    clear_wr();
    checkpoint_waitrequest = 1'b1;
    phys_tab[0] = 4'hC; phys_tab[1] = 4'hD;
    start_ckpt(4'h6, 3'd2);
    repeat (6) tick();
    check_eq("mid_write", 32'(checkpoint_write), 32'd1);
    check_eq("mid_level", 32'(fifo_level), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("arst_write", 32'(checkpoint_write), 32'd0);
    check_eq("arst_level", 32'(fifo_level), 32'd0);
    check_eq("arst_addr", checkpoint_address, 32'h0);
    repeat (2) tick();
    checkpoint_waitrequest = 1'b0;
    reset_n = 1'b1;
    clear_wr();
    repeat (10) tick();
    check_eq("post_rst_nwr", 32'(wr_addr_q.size()), 32'd0);
    check_eq("post_rst_write", 32'(checkpoint_write), 32'd0);

`ifdef CHECKPOINT_TIMEOUT_EN
    // Stuck waitrequest: first write dropped after 16 cycles, second written normally
    clear_wr();
    checkpoint_waitrequest = 1'b1;
    phys_tab[0] = 4'h1; phys_tab[1] = 4'h2;
    start_ckpt(4'h7, 3'd2);
    for (int k = 0; k < 20; k++) begin
      if (checkpoint_write) break;
      tick();
    end
    n = 0;
    while (checkpoint_write && n < 40) begin
      tick();
      n++;
    end
    check_eq("to_wr_cycles", 32'(n), 32'd16);
    check_eq("to_err_set", 32'(timeout_err), 32'd1);
    check_eq("to_nwr", 32'(wr_addr_q.size()), 32'd0);
    checkpoint_waitrequest = 1'b0;
    repeat (6) tick();
    check_eq("to_next_nwr", 32'(wr_addr_q.size()), 32'd1);
    expect_wr("to_next", 0, 32'h0020_0000, 32'h127);
    check_eq("to_err_sticky", 32'(timeout_err), 32'd1);
`else
    check_eq("terr_tied", 32'(timeout_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
